// File: rtl/riscv_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master)
// and instruction memory (slave).
interface riscv_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/riscv_fetch_unit.sv
// RISC-V instruction fetch stage: one outstanding imem request, registered
// instruction with decoded fields, and controller-driven PC redirect.
module riscv_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_fetch_unit_if.master   imem,
  input  logic                 PC_src,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instr,
  output logic [XLEN-1:0]      instr_pc,
  output logic [6:0]           OP,
  output logic [2:0]           F3,
  output logic                 F7,
  output logic [4:0]           rd,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_pc_q;
  logic [31:0]     instr_q;
  logic            drop_q;
  logic            instr_valid_q;
  logic [XLEN-1:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      if (PC_src) pc_q <= redirect_tgt;
      case (state_q)
        S_REQ: begin
          // A redirect that coincides with acceptance still launches the old-pc
          // request, so its response must be thrown away.
          if (imem.imem_req_ready) begin
            state_q <= S_WAIT;
            drop_q  <= PC_src;
          end
        end
        S_WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (drop_q || PC_src) begin
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              instr_q       <= imem.imem_rsp_data;
              instr_pc_q    <= pc_q;
              pc_q          <= pc_q + XLEN'(4);
              instr_valid_q <= 1'b1;
              state_q       <= S_HOLD;
            end
          end else if (PC_src) begin
            drop_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (PC_src || instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign imem.imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem.imem_addr      = pc_q;

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign OP          = instr_q[6:0];
  assign F3          = instr_q[14:12];
  assign F7          = instr_q[30];
  assign rd          = instr_q[11:7];
  assign rs1         = instr_q[19:15];
  assign rs2         = instr_q[24:20];

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: transaction-level model with a
// per-cycle compare, directed scenarios, and a wrap/reset instance.
module tb_riscv_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  // Main instance (RESET_PC = 0), driven by the bench memory below.
  riscv_fetch_unit_if #(.XLEN(32)) imem0 ();
  logic        PC_src, instr_ready;
  logic [31:0] redirect_pc;
  logic        instr_valid, F7;
  logic [31:0] instr, instr_pc;
  logic [6:0]  OP;
  logic [2:0]  F3;
  logic [4:0]  rd, rs1, rs2;

  riscv_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem(imem0),
    .PC_src(PC_src), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .OP(OP), .F3(F3), .F7(F7), .rd(rd), .rs1(rs1), .rs2(rs2)
  );

  // Second instance near the top of the address space, driven by hand.
  riscv_fetch_unit_if #(.XLEN(32)) imem1 ();
  logic        pc_src1, instr_ready1;
  logic [31:0] redirect1;
  logic        valid1, f71;
  logic [31:0] instr1, ipc1;
  logic [6:0]  op1;
  logic [2:0]  f31;
  logic [4:0]  rd1, rs11, rs21;

  riscv_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem(imem1),
    .PC_src(pc_src1), .redirect_pc(redirect1),
    .instr_valid(valid1), .instr_ready(instr_ready1),
    .instr(instr1), .instr_pc(ipc1),
    .OP(op1), .F3(f31), .F7(f71), .rd(rd1), .rs1(rs11), .rs2(rs21)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0093;  // addi x1,x0,5
      32'h0000_0004: mem_word = 32'h00A0_0113;  // addi x2,x0,10
      32'h0000_0100: mem_word = 32'h0030_0193;  // addi x3,x0,3
      default:       mem_word = {a[24:0], 7'h13};
    endcase
  endfunction

  // Instruction memory for the main instance: fixed latency per request.
  int          lat = 1;
  int          left;
  bit          pend;
  logic [31:0] paddr;

  task automatic tick();
    logic        acc;
    logic [31:0] a;
    logic        was_rst;
    @(negedge clk);
    acc     = imem0.imem_req_valid && imem0.imem_req_ready;
    a       = imem0.imem_addr;
    was_rst = rst;
    @(posedge clk);
    #1;
    if (was_rst) begin
      imem0.imem_rsp_valid = 1'b0;
      pend = 1'b0;
    end else begin
      if (imem0.imem_rsp_valid) imem0.imem_rsp_valid = 1'b0;
      if (acc) begin
        pend  = 1'b1;
        left  = lat - 1;
        paddr = a;
      end else if (pend && left > 0) begin
        left--;
      end
      if (pend && left == 0) begin
        imem0.imem_rsp_valid = 1'b1;
        imem0.imem_rsp_data  = mem_word(paddr);
        pend = 1'b0;
      end
    end
  endtask

  // Transaction-level model: is a request outstanding, is its answer stale,
  // is a fetched instruction being held for the consumer.
  logic [31:0] m_pc, m_instr, m_ipc;
  logic        m_out, m_stale, m_held;

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 32'h0; m_out <= 1'b0; m_stale <= 1'b0; m_held <= 1'b0;
      m_instr <= 32'h0; m_ipc <= 32'h0;
    end else if (m_held) begin
      if (PC_src || instr_ready) m_held <= 1'b0;
      if (PC_src) m_pc <= {redirect_pc[31:2], 2'b00};
    end else if (m_out) begin
      if (imem0.imem_rsp_valid) begin
        m_out   <= 1'b0;
        m_stale <= 1'b0;
        if (!m_stale && !PC_src) begin
          m_held  <= 1'b1;
          m_instr <= imem0.imem_rsp_data;
          m_ipc   <= m_pc;
          m_pc    <= m_pc + 32'd4;
        end
      end else if (PC_src) begin
        m_stale <= 1'b1;
      end
      if (PC_src) m_pc <= {redirect_pc[31:2], 2'b00};
    end else begin
      if (imem0.imem_req_ready) begin
        m_out   <= 1'b1;
        m_stale <= PC_src;
      end
      if (PC_src) m_pc <= {redirect_pc[31:2], 2'b00};
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("req_valid", 32'(imem0.imem_req_valid), 32'(!rst && !m_out && !m_held));
      check("imem_addr", imem0.imem_addr, m_pc);
      check("instr_valid", 32'(instr_valid), 32'(m_held));
      if (m_held) begin
        check("instr", instr, m_instr);
        check("instr_pc", instr_pc, m_ipc);
        check("OP", 32'(OP), m_instr & 32'h7F);
        check("F3", 32'(F3), (m_instr >> 12) & 32'h7);
        check("F7", 32'(F7), (m_instr >> 30) & 32'h1);
        check("rd", 32'(rd), (m_instr >> 7) & 32'h1F);
        check("rs1", 32'(rs1), (m_instr >> 15) & 32'h1F);
        check("rs2", 32'(rs2), (m_instr >> 20) & 32'h1F);
      end
    end
  end

  task automatic wait_valid(input string name);
    int n = 0;
    do begin tick(); n++; end while (!instr_valid && n < 50);
    check({name, "_timeout"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    do begin tick(); n++; end while (!imem0.imem_req_valid && n < 50);
    check({name, "_timeout"}, 32'(imem0.imem_req_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    PC_src = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    imem0.imem_req_ready = 1'b1; imem0.imem_rsp_valid = 1'b0; imem0.imem_rsp_data = 32'h0;
    pc_src1 = 1'b0; redirect1 = 32'h0; instr_ready1 = 1'b1;
    imem1.imem_req_ready = 1'b0; imem1.imem_rsp_valid = 1'b0; imem1.imem_rsp_data = 32'h0;

    // T1 reset
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t1_addr", imem0.imem_addr, 32'h0);
    check("t1_req_valid", 32'(imem0.imem_req_valid), 32'd1);
    check("t1_instr_valid", 32'(instr_valid), 32'd0);

    // T2 sequential fetch with zero-wait memory
    wait_valid("t2_first");
    check("t2_pc0", instr_pc, 32'h0);
    check("t2_op0", 32'(OP), 32'h13);
    check("t2_rd0", 32'(rd), 32'd1);
    wait_valid("t2_second");
    check("t2_pc4", instr_pc, 32'h4);
    check("t2_rd4", 32'(rd), 32'd2);

    // T3 backpressure: instruction held, no new request
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", 32'(instr_valid), 32'd1);
      check("t3_hold_pc", instr_pc, 32'h4);
      check("t3_no_req", 32'(imem0.imem_req_valid), 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    check("t3_released", 32'(instr_valid), 32'd0);
    check("t3_next_addr", imem0.imem_addr, 32'h8);

    // T4 redirect while waiting on a slow response
    lat = 3;
    tick();
    check("t4_waiting", 32'(imem0.imem_req_valid), 32'd0);
    PC_src = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    PC_src = 1'b0;
    check("t4_pc_redirected", imem0.imem_addr, 32'h100);
    wait_req("t4_req");
    check("t4_req_addr", imem0.imem_addr, 32'h100);
    lat = 1;
    wait_valid("t4_deliver");
    check("t4_instr_pc", instr_pc, 32'h100);
    check("t4_rd", 32'(rd), 32'd3);

    // T5 redirect in hold with simultaneous consume
    PC_src = 1'b1; redirect_pc = 32'h0000_0200; instr_ready = 1'b1;
    tick();
    PC_src = 1'b0;
    check("t5_flushed", 32'(instr_valid), 32'd0);
    check("t5_req_valid", 32'(imem0.imem_req_valid), 32'd1);
    check("t5_req_addr", imem0.imem_addr, 32'h200);
    wait_valid("t5_deliver");
    check("t5_instr_pc", instr_pc, 32'h200);

    // Redirect while requesting: first stalled, then coinciding with acceptance
    imem0.imem_req_ready = 1'b0;
    wait_req("r_req");
    PC_src = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    PC_src = 1'b0;
    check("r_stall_addr", imem0.imem_addr, 32'h300);
    check("r_stall_req", 32'(imem0.imem_req_valid), 32'd1);
    imem0.imem_req_ready = 1'b1; PC_src = 1'b1; redirect_pc = 32'h0000_0400;
    tick();
    PC_src = 1'b0;
    check("r_accept_addr", imem0.imem_addr, 32'h400);
    wait_valid("r_deliver");
    check("r_instr_pc", instr_pc, 32'h400);

    // T6 PC wrap and mid-operation reset on the high-RESET_PC instance
    imem0.imem_req_ready = 1'b0;
    check("t6_reset_addr", imem1.imem_addr, 32'hFFFF_FFFC);
    check("t6_reset_req", 32'(imem1.imem_req_valid), 32'd1);
    imem1.imem_req_ready = 1'b1;
    tick();
    imem1.imem_req_ready = 1'b0;
    check("t6_wait", 32'(imem1.imem_req_valid), 32'd0);
    imem1.imem_rsp_valid = 1'b1; imem1.imem_rsp_data = 32'h0000_0013;
    tick();
    imem1.imem_rsp_valid = 1'b0;
    check("t6_valid", 32'(valid1), 32'd1);
    check("t6_instr_pc", ipc1, 32'hFFFF_FFFC);
    tick();
    check("t6_wrap_addr", imem1.imem_addr, 32'h0);
    check("t6_wrap_req", 32'(imem1.imem_req_valid), 32'd1);
    imem1.imem_req_ready = 1'b1;
    tick();
    imem1.imem_req_ready = 1'b0;
    check("t6_wait2", 32'(imem1.imem_req_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("t6_req_low_in_rst", 32'(imem1.imem_req_valid), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t6_rst_addr", imem1.imem_addr, 32'hFFFF_FFFC);
    check("t6_rst_req", 32'(imem1.imem_req_valid), 32'd1);
    check("t6_rst_valid", 32'(valid1), 32'd0);
    check("t6_main_addr", imem0.imem_addr, 32'h0);
    check("t6_main_valid", 32'(instr_valid), 32'd0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
